// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// function codes and the mux/ALU select fields.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALUOp and the R-type Funct field.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALUC_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:  ALUControl = ALUC_ADD;
          FN_SUB:  ALUControl = ALUC_SUB;
          FN_AND:  ALUControl = ALUC_AND;
          FN_OR:   ALUControl = ALUC_OR;
          FN_SLT:  ALUControl = ALUC_SLT;
          default: ALUControl = ALUC_ADD;
        endcase
      end
      default: ALUControl = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// with memory-ready stalls, plus the ALU control decoder.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ALUControl,
  output logic [3:0] State
);

  state_t state, state_nxt;
  logic   memreq_c, memwrite_c, irwrite_c, pcwrite_c, branch_c;
  logic   regwrite_c, done_c, illegal_c;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = S_FETCH;
    memreq_c   = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    regwrite_c = 1'b0;
    done_c     = 1'b0;
    illegal_c  = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = PCSRC_ALURES;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        memreq_c  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        irwrite_c = MemReady;
        pcwrite_c = MemReady;
        state_nxt = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH2;
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEXEC;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memreq_c  = 1'b1;
        IorD      = 1'b1;
        state_nxt = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      S_MEMWR: begin
        memreq_c   = 1'b1;
        IorD       = 1'b1;
        memwrite_c = 1'b1;
        done_c     = MemReady;
        state_nxt  = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        branch_c = 1'b1;
        PCSrc    = PCSRC_ALUOUT;
        done_c   = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = PCSRC_JUMP;
        pcwrite_c = 1'b1;
        done_c    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset masks every side-effecting strobe so an aborted access never commits.
  assign MemReq    = memreq_c   & rst_n;
  assign MemWrite  = memwrite_c & rst_n;
  assign IRWrite   = irwrite_c  & rst_n;
  assign PCWrite   = pcwrite_c  & rst_n;
  assign Branch    = branch_c   & rst_n;
  assign RegWrite  = regwrite_c & rst_n;
  assign InstrDone = done_c     & rst_n;
  assign Illegal   = illegal_c  & rst_n;
  assign State     = state;

  alu_decoder u_alu_decoder (
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       MemReady;
  logic       MemReq, MemWrite, IorD, IRWrite, PCWrite, Branch, ALUSrcA;
  logic       RegDst, MemtoReg, RegWrite, InstrDone, Illegal;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .InstrDone(InstrDone),
    .Illegal(Illegal), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock, then let combinational outputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; Op = 6'b000000; Funct = 6'b000000; MemReady = 1'b1;
    tick();
    chk("rst_state", {4'd0, State}, 8'd0);
    chk("rst_memreq", {7'd0, MemReq}, 8'd0);
    chk("rst_irwrite", {7'd0, IRWrite}, 8'd0);
    chk("rst_pcwrite", {7'd0, PCWrite}, 8'd0);

    // lw with memory always ready: 0,1,2,3,4,0
    rst_n = 1'b1; Op = 6'b100011; #1;
    chk("lw_f_state", {4'd0, State}, 8'd0);
    chk("lw_f_strobes", {4'd0, MemReq, IRWrite, PCWrite, IorD}, 8'b1110);
    chk("lw_f_srcb", {6'd0, ALUSrcB}, 8'd1);
    tick();
    chk("lw_d_state", {4'd0, State}, 8'd1);
    chk("lw_d_srcb", {6'd0, ALUSrcB}, 8'd3);
    tick();
    chk("lw_ma_state", {4'd0, State}, 8'd2);
    chk("lw_ma_sel", {5'd0, ALUSrcA, ALUSrcB}, 8'b110);
    tick();
    chk("lw_mr_state", {4'd0, State}, 8'd3);
    chk("lw_mr_sel", {4'd0, MemReq, IorD, MemWrite, RegWrite}, 8'b1100);
    tick();
    chk("lw_wb_state", {4'd0, State}, 8'd4);
    chk("lw_wb_out", {4'd0, RegWrite, MemtoReg, RegDst, InstrDone}, 8'b1101);
    tick();
    chk("lw_end_state", {4'd0, State}, 8'd0);
    chk("lw_end_out", {5'd0, RegWrite, MemtoReg, InstrDone}, 8'd0);

    // fetch stall, then sw with three not-ready cycles in MEMWR
    MemReady = 1'b0; Op = 6'b101011; #1;
    chk("fstall_ir", {6'd0, IRWrite, PCWrite}, 8'd0);
    tick();
    chk("fstall_state", {4'd0, State}, 8'd0);
    chk("fstall_memreq", {7'd0, MemReq}, 8'd1);
    MemReady = 1'b1;
    tick(); tick();
    MemReady = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall_state", {4'd0, State}, 8'd5);
      chk("sw_stall_out", {4'd0, MemReq, IorD, MemWrite, InstrDone}, 8'b1110);
      tick();
    end
    MemReady = 1'b1; #1;
    chk("sw_rdy_state", {4'd0, State}, 8'd5);
    chk("sw_rdy_out", {4'd0, MemReq, IorD, MemWrite, InstrDone}, 8'b1111);
    tick();
    chk("sw_end_state", {4'd0, State}, 8'd0);
    chk("sw_end_memwrite", {7'd0, MemWrite}, 8'd0);

    // R-type slt
    Op = 6'b000000; Funct = 6'b101010;
    tick(); tick();
    chk("slt_ex_state", {4'd0, State}, 8'd6);
    chk("slt_ex_aluop", {6'd0, ALUOp}, 8'd2);
    chk("slt_ex_aluctl", {5'd0, ALUControl}, 8'b111);
    chk("slt_ex_src", {5'd0, ALUSrcA, ALUSrcB}, 8'b100);
    tick();
    chk("slt_wb_state", {4'd0, State}, 8'd7);
    chk("slt_wb_out", {4'd0, RegDst, RegWrite, MemtoReg, InstrDone}, 8'b1101);
    tick();

    // R-type or
    Funct = 6'b100101;
    tick(); tick();
    chk("or_aluctl", {5'd0, ALUControl}, 8'b001);
    tick(); tick();

    // beq
    Op = 6'b000100; Funct = 6'b100101;
    tick(); tick();
    chk("beq_state", {4'd0, State}, 8'd8);
    chk("beq_aluctl", {5'd0, ALUControl}, 8'b110);
    chk("beq_out", {3'd0, Branch, PCWrite, PCSrc, InstrDone}, 8'b10011);
    tick();

    // j
    Op = 6'b000010;
    tick(); tick();
    chk("j_state", {4'd0, State}, 8'd11);
    chk("j_out", {5'd0, PCWrite, PCSrc}, 8'b110);
    chk("j_done", {7'd0, InstrDone}, 8'd1);
    tick();

    // addi
    Op = 6'b001000;
    tick(); tick();
    chk("addi_ex_state", {4'd0, State}, 8'd9);
    chk("addi_ex_sel", {5'd0, ALUSrcA, ALUSrcB}, 8'b110);
    tick();
    chk("addi_wb_state", {4'd0, State}, 8'd10);
    chk("addi_wb_out", {4'd0, RegWrite, RegDst, MemtoReg, InstrDone}, 8'b1001);
    tick();

    // illegal opcode
    Op = 6'b111111;
    tick();
    chk("ill_state", {4'd0, State}, 8'd1);
    chk("ill_out", {5'd0, Illegal, RegWrite, MemWrite}, 8'b100);
    tick();
    chk("ill_next", {4'd0, State}, 8'd0);
    chk("ill_clear", {7'd0, Illegal}, 8'd0);

    // reset during a stalled MEMRD
    Op = 6'b100011;
    tick(); tick(); tick();
    MemReady = 1'b0;
    tick();
    chk("mr_stall_state", {4'd0, State}, 8'd3);
    rst_n = 1'b0; #1;
    chk("mr_rst_en", {2'd0, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Branch}, 8'd0);
    chk("mr_rst_done", {6'd0, InstrDone, Illegal}, 8'd0);
    tick();
    rst_n = 1'b1; #1;
    chk("mr_post_state", {4'd0, State}, 8'd0);
    chk("mr_post_ir", {6'd0, IRWrite, RegWrite}, 8'd0);

    // reset during a stalled MEMWR
    MemReady = 1'b1; Op = 6'b101011;
    tick(); tick();
    MemReady = 1'b0;
    tick();
    chk("mw_stall_state", {4'd0, State}, 8'd5);
    rst_n = 1'b0; #1;
    chk("mw_rst_en", {5'd0, MemReq, MemWrite, InstrDone}, 8'd0);
    tick();
    rst_n = 1'b1; #1;
    chk("mw_post_state", {4'd0, State}, 8'd0);
    chk("mw_post_memwrite", {7'd0, MemWrite}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have inputs Op[5:0] (instruction opcode), Funct[5:0] (R-type function field), MemReady (1 = memory completes current access this cycle).
REQ-004 SHALL have 1-bit outputs MemReq, MemWrite, IorD, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite, InstrDone, Illegal.
REQ-005 SHALL have outputs PCSrc[1:0] (00 ALUResult, 01 ALUOut, 10 jump target), ALUSrcB[1:0] (00 B, 01 const 4, 10 SignImm, 11 SignImm<<2), ALUOp[1:0] (00 add, 01 sub, 10 per Funct), ALUControl[2:0], State[3:0] (debug).

Function
REQ-006 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; State output equals the encoding.
REQ-007 SHALL decode opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-008 FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=MemReady; stay while MemReady=0, else go DECODE.
REQ-009 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next MEMADR (lw/sw), EXECUTE (R-type), BRANCH (beq), ADDIEXEC (addi), JUMP (j); any other Op -> FETCH with Illegal=1 for that cycle.
REQ-010 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD (lw) or MEMWR (sw).
REQ-011 MEMRD: MemReq=1, IorD=1; stay while MemReady=0, else MEMWB.
REQ-012 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-013 MEMWR: MemReq=1, IorD=1, MemWrite=1; stay while MemReady=0, else FETCH.
REQ-014 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-015 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01; next FETCH.
REQ-016 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-017 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-018 Any output not listed for a state SHALL be 0 (multi-bit: 00).
REQ-019 InstrDone SHALL be 1 for exactly one cycle in each terminal state: MEMWB, MEMWR with MemReady=1, ALUWB, BRANCH, ADDIWB, JUMP.
REQ-020 ALUControl SHALL be combinational from (ALUOp, Funct): 00->010, 01->110, 10 with Funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other Funct->010.
REQ-021 MemReq SHALL remain 1 and all address/data selects stable for every stalled cycle; MemWrite SHALL never assert outside MEMWR.
REQ-022 Op and Funct SHALL be sampled only in DECODE/MEMADR/EXECUTE (instruction register stable); no internal latch of Op.
REQ-023 Unreachable encodings 12-15 SHALL transition to FETCH next cycle with all outputs 0.

Reset
REQ-024 While rst_n=0 at a rising edge, state SHALL become FETCH.
REQ-025 While rst_n=0, all write enables (MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Branch), InstrDone and Illegal SHALL be forced 0 regardless of state.
REQ-026 Reset asserted mid-instruction (including a stalled MEMWR) SHALL abort it; first cycle after release is FETCH with no prior write completed by the controller.

Structure
REQ-027 State encodings, opcode constants, ALUOp/ALUSrcB/PCSrc encodings SHALL live in shared package mips_pkg.
REQ-028 ALUControl SHALL come from one instantiated sub-module, alu_decoder; the FSM SHALL be state register plus next-state and output decoders.

Verification
REQ-029 Reset then lw (Op=100011), MemReady=1 always -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrDone in state 4.
REQ-030 sw with MemReady=0 for 3 cycles in MEMWR -> State=5 for 4 cycles, MemWrite=1 each, InstrDone only on the MemReady=1 cycle.
REQ-031 R-type Funct=101010 -> EXECUTE shows ALUOp=10, ALUControl=111; ALUWB RegDst=1, RegWrite=1.
REQ-032 beq -> BRANCH: ALUControl=110, Branch=1, PCSrc=01, PCWrite=0; j -> JUMP: PCWrite=1, PCSrc=10.
REQ-033 Op=111111 -> DECODE Illegal=1, next FETCH, no RegWrite/MemWrite.
REQ-034 rst_n=0 for one cycle while in MEMRD stalled -> next State=0, all enables 0 during reset cycle.
